clk_div_bank: RTL and testbench

Parametrised multi-channel clock divider. It generates N_CH free-running divided square waves and per-channel period ticks from the single system clock. Channel divisors are loaded glitch-free at runtime through a valid/ready port, each channel has its own enable, and a global sync input re-phases all channels together. It sits at the top of the clock tree and feeds the counting, scan and blink logic; at defaults it reproduces the 1 kHz / 100 Hz / 2 Hz / 1 Hz set from a 50 MHz clock.

---
 rtl/clk_div_bank_if.sv | 14 +
 rtl/clk_div_bank.sv | 90 +++++++++
 tb/tb_clk_div_bank.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_bank_if.sv
// Divisor load port for clk_div_bank: master offers a channel/divisor pair,
// slave raises ready while that channel has no update waiting.
interface clk_div_bank_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 27
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_bank.sv
// N_CH free-running dividers with per-period ticks; outputs registered one edge after the count state.
// Divisor loads stall (cfg_ready low) while the addressed channel already holds an unapplied divisor.
module clk_div_bank #(
  parameter int                    N_CH     = 4,
  parameter int                    CNT_W    = 27,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {27'd50000000, 27'd25000000, 27'd500000, 27'd50000},
  parameter int                    CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] en,
  input  logic            sync,
  clk_div_bank_if.slave   cfg,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick,
  output logic            high
);

  function automatic logic [CNT_W-1:0] clamp2(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  logic [CNT_W-1:0] cnt      [N_CH];
  logic [CNT_W-1:0] div      [N_CH];
  logic [CNT_W-1:0] pend_div [N_CH];
  logic [CNT_W:0]   half     [N_CH];
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  last;
  logic [N_CH-1:0]  take;
  logic             ready;

  assign high          = 1'b1;
  assign cfg.cfg_ready = ready;

  // Out-of-range channel selects are always ready so the request drains harmlessly.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(cfg.cfg_ch) == i) ready = ~pend[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      half[i] = ({1'b0, div[i]} + (CNT_W+1)'(1)) >> 1;
      last[i] = (cnt[i] == div[i] - CNT_W'(1));
      take[i] = cfg.cfg_valid && ready && (int'(cfg.cfg_ch) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]      <= '0;
        div[i]      <= clamp2(DIV_INIT[i*CNT_W +: CNT_W]);
        pend_div[i] <= clamp2(DIV_INIT[i*CNT_W +: CNT_W]);
        pend[i]     <= 1'b0;
        clk_out[i]  <= 1'b0;
        tick[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync || !en[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          if (pend[i]) begin
            div[i]  <= pend_div[i];
            pend[i] <= 1'b0;
          end
        end else begin
          cnt[i]     <= last[i] ? '0 : cnt[i] + CNT_W'(1);
          clk_out[i] <= ({1'b0, cnt[i]} < half[i]);
          tick[i]    <= last[i];
          // New divisors only land on a period boundary, so no runt pulses.
          if (last[i] && pend[i]) begin
            div[i]  <= pend_div[i];
            pend[i] <= 1'b0;
          end
        end
        // A load accepted on a wrap edge waits for the following wrap.
        if (take[i]) begin
          pend_div[i] <= clamp2(cfg.cfg_div);
          pend[i]     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed and randomized checks of clk_div_bank against a timestamp-based period model.
module tb_clk_div_bank;
  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic       sync;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic       high;

  clk_div_bank_if #(.CH_W(2), .CNT_W(8)) cfg ();

  clk_div_bank #(
    .N_CH(4), .CNT_W(8), .DIV_INIT({8'd10, 8'd7, 8'd4, 8'd2})
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg(cfg),
    .clk_out(clk_out), .tick(tick), .high(high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: each channel remembers the edge index at which its current period began.
  int         n;
  int         start [4];
  int         mdiv  [4];
  int         mpdiv [4];
  bit         mpend [4];
  logic [3:0] eclk;
  logic [3:0] etick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    mdiv = '{2, 4, 7, 10};
    for (int i = 0; i < 4; i++) begin
      start[i] = 0;
      mpend[i] = 1'b0;
      mpdiv[i] = mdiv[i];
    end
    eclk  = '0;
    etick = '0;
  endtask

  task automatic model_edge();
    int ch;
    int p;
    bit acc;
    ch  = int'(cfg.cfg_ch);
    acc = cfg.cfg_valid && !mpend[ch];
    for (int i = 0; i < 4; i++) begin
      if (sync || !en[i]) begin
        eclk[i]  = 1'b0;
        etick[i] = 1'b0;
        start[i] = n + 1;
        if (mpend[i]) begin mdiv[i] = mpdiv[i]; mpend[i] = 1'b0; end
      end else begin
        p        = n - start[i];
        eclk[i]  = (p < (mdiv[i] + 1) / 2);
        etick[i] = (p == mdiv[i] - 1);
        if (etick[i]) begin
          start[i] = n + 1;
          if (mpend[i]) begin mdiv[i] = mpdiv[i]; mpend[i] = 1'b0; end
        end
      end
    end
    if (acc) begin
      mpdiv[ch] = (int'(cfg.cfg_div) < 2) ? 2 : int'(cfg.cfg_div);
      mpend[ch] = 1'b1;
    end
    n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_out", 32'(clk_out), 32'(eclk));
    chk("tick", 32'(tick), 32'(etick));
    chk("cfg_ready", 32'(cfg.cfg_ready), 32'(!mpend[cfg.cfg_ch]));
    chk("high", 32'(high), 32'd1);
  endtask

  task automatic steps(input int k);
    for (int j = 0; j < k; j++) step();
  endtask

  task automatic load(input logic [1:0] ch, input logic [7:0] d);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = ch;
    cfg.cfg_div   = d;
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    int b;
    rst = 1'b1;
    en = 4'hF;
    sync = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = 2'd0;
    cfg.cfg_div = 8'd0;
    model_reset();
    #1;
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_ready", 32'(cfg.cfg_ready), 32'h1);
    chk("reset_high", 32'(high), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step();
    chk("first_high", 32'(clk_out), 32'hF);
    steps(23);

    // ch3 10 -> 6 loaded mid-period
    steps($urandom_range(1, 8));
    load(2'd3, 8'd6);
    chk("ch3_ready_drop", 32'(cfg.cfg_ready), 32'h0);
    steps(25);

    // divisor below 2 is clamped
    load(2'd1, 8'd0);
    steps(12);

    // ch2 disabled for five edges
    en[2] = 1'b0;
    steps(5);
    chk("ch2_off", 32'({clk_out[2], tick[2]}), 32'h0);
    en[2] = 1'b1;
    steps(10);

    // pending ch2 divisor applied by sync
    load(2'd2, 8'($urandom_range(2, 12)));
    steps($urandom_range(0, 3));
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_zero", 32'(clk_out), 32'h0);
    step();
    chk("sync_aligned", 32'(clk_out), 32'hF);
    steps(20);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, 3);
        en[b] = ~en[b];
      end
      cfg.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg.cfg_ch    = 2'($urandom_range(0, 3));
      cfg.cfg_div   = 8'($urandom_range(0, 15));
      sync          = ($urandom_range(0, 29) == 0);
      step();
    end
    cfg.cfg_valid = 1'b0;
    sync = 1'b0;
    en = 4'hF;
    steps(12);

    // reset mid-run with an update pending
    load(2'd0, 8'd9);
    steps(3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_clk_out", 32'(clk_out), 32'h0);
    chk("async_tick", 32'(tick), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      cfg.cfg_ch = 2'(c);
      #1;
      chk("post_reset_ready", 32'(cfg.cfg_ready), 32'h1);
    end
    steps(30);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
